// File: rtl/btn_event_arbiter.sv
// btn_event_arbiter
// Latches one-cycle button press pulses into per-button pending bits,
// round-robin arbitrates the pending presses into a small show-ahead event
// FIFO, and presents button indices to the consumer over valid/ready.
// Optional feature macro: BTN_EVT_DROP_CNT_EN adds an 8-bit saturating
// counter of merged (absorbed) presses on o_merge_cnt.
module btn_event_arbiter #(
    parameter int N_BTN      = 5,
    parameter int FIFO_DEPTH = 4,
    localparam int IDX_W     = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] i_btn_pulse,
    output logic             o_evt_valid,
    output logic [IDX_W-1:0] o_evt_idx,
    input  logic             i_evt_ready,
    output logic [N_BTN-1:0] o_pending,
    output logic             o_fifo_full,
`ifdef BTN_EVT_DROP_CNT_EN
    output logic [7:0]       o_merge_cnt,
`endif
    output logic             o_merge
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    // Arbiter decision states: IDLE means nothing is pushed this cycle
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [N_BTN-1:0] pending;
    logic [IDX_W-1:0] rr_ptr;
    logic             merge;

    logic [IDX_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic [0:0]       arb_state;
    logic             grant_found;
    logic [IDX_W-1:0] grant_idx;
    logic [N_BTN-1:0] grant_mask;
    logic [IDX_W:0]   cand_wide;
    logic [IDX_W-1:0] cand;
    logic             push;
    logic             pop;
    logic             merge_hit;

    // Pick the state: grant only when something is pending and the FIFO has room
    always_comb begin
        arb_state = ST_IDLE;
        if ((pending != '0) && (count < DEPTH_CNT)) begin
            arb_state = ST_GRANT;
        end
    end

    // Search upward from rr_ptr (modulo N_BTN) for the first pending button
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_wide   = '0;
        cand        = '0;
        for (int i = 0; i < N_BTN; i++) begin
            cand_wide = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (cand_wide >= (IDX_W+1)'(N_BTN)) begin
                cand_wide = cand_wide - (IDX_W+1)'(N_BTN);
            end
            cand = cand_wide[IDX_W-1:0];
            if (!grant_found && pending[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Decode the grant into a one-hot mask and derive push/pop/merge strobes
    always_comb begin
        push = (arb_state == ST_GRANT) && grant_found;
        pop  = (count != '0) && i_evt_ready;
        grant_mask = '0;
        for (int k = 0; k < N_BTN; k++) begin
            grant_mask[k] = push && (grant_idx == IDX_W'(k));
        end
        merge_hit = |(i_btn_pulse & pending & ~grant_mask);
    end

    // Pending latches: a granted bit clears, but a same-cycle press re-sets it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
            merge   <= 1'b0;
        end else begin
            pending <= (pending & ~grant_mask) | i_btn_pulse;
            merge   <= merge_hit;
        end
    end

    // Round-robin pointer moves just past the most recently granted button
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (push) begin
            if (grant_idx == IDX_W'(N_BTN - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= grant_idx + 1'b1;
            end
        end
    end

    // FIFO storage: data needs no reset because valid gates the output
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= grant_idx;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef BTN_EVT_DROP_CNT_EN
    logic [7:0] merge_cnt;
    logic       cnt_clear;

    // Counter clears when the consumer takes a final index-0 event, emptying the FIFO
    always_comb begin
        cnt_clear = pop && (o_evt_idx == '0) && (count == CNT_W'(1)) && !push;
    end

    // Saturating count of absorbed presses; the clear condition takes priority
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            merge_cnt <= '0;
        end else if (cnt_clear) begin
            merge_cnt <= '0;
        end else if (merge_hit && (merge_cnt != 8'hFF)) begin
            merge_cnt <= merge_cnt + 1'b1;
        end
    end

    assign o_merge_cnt = merge_cnt;
`endif

    assign o_evt_valid = (count != '0);
    assign o_evt_idx   = o_evt_valid ? mem[rd_ptr] : '0;
    assign o_pending   = pending;
    assign o_fifo_full = (count == DEPTH_CNT);
    assign o_merge     = merge;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// tb_btn_event_arbiter
// Self-checking bench for btn_event_arbiter: a queue-based reference model
// predicts pending bits, FIFO occupancy and event order; a monitor pops the
// expected event scoreboard on every valid/ready handshake.
// Honors BTN_EVT_DROP_CNT_EN when defined.
module tb_btn_event_arbiter;

    localparam int N_BTN      = 5;
    localparam int FIFO_DEPTH = 4;
    localparam int IDX_W      = $clog2(N_BTN);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N_BTN-1:0] btn = '0;
    logic             rdy = 1'b0;
    logic             o_evt_valid;
    logic [IDX_W-1:0] o_evt_idx;
    logic [N_BTN-1:0] o_pending;
    logic             o_fifo_full;
    logic             o_merge;
`ifdef BTN_EVT_DROP_CNT_EN
    logic [7:0]       o_merge_cnt;
`endif

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [N_BTN-1:0] m_pending;
    int               m_rr;
    int               fifo_q[$];
    int               sb_q[$];
    logic             m_merge;
    int               m_cnt;

    btn_event_arbiter #(
        .N_BTN(N_BTN),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_btn_pulse(btn),
        .o_evt_valid(o_evt_valid),
        .o_evt_idx(o_evt_idx),
        .i_evt_ready(rdy),
        .o_pending(o_pending),
        .o_fifo_full(o_fifo_full),
`ifdef BTN_EVT_DROP_CNT_EN
        .o_merge_cnt(o_merge_cnt),
`endif
        .o_merge(o_merge)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pending = '0;
        m_rr      = 0;
        m_merge   = 1'b0;
        m_cnt     = 0;
        fifo_q.delete();
        sb_q.delete();
    endtask

    // One clock edge of the reference behaviour, from the current inputs
    task automatic model_step(input logic [N_BTN-1:0] p, input logic r);
        bit pop_now;
        int grant;
        bit merge_now;
        bit clr;
        pop_now = (fifo_q.size() != 0) && r;
        grant   = -1;
        if ((m_pending != '0) && (fifo_q.size() < FIFO_DEPTH)) begin
            for (int i = 0; i < N_BTN; i++) begin
                int k;
                k = (m_rr + i) % N_BTN;
                if (grant < 0 && m_pending[k]) grant = k;
            end
        end
        merge_now = 1'b0;
        for (int k = 0; k < N_BTN; k++) begin
            if (p[k] && m_pending[k] && (k != grant)) merge_now = 1'b1;
        end
        clr = pop_now && (fifo_q[0] == 0) && (fifo_q.size() == 1) && (grant < 0);
        if (clr) m_cnt = 0;
        else if (merge_now && m_cnt < 255) m_cnt++;
        if (pop_now) void'(fifo_q.pop_front());
        if (grant >= 0) begin
            fifo_q.push_back(grant);
            sb_q.push_back(grant);
            m_pending[grant] = 1'b0;
            m_rr = (grant + 1) % N_BTN;
        end
        m_pending = m_pending | p;
        m_merge   = merge_now;
    endtask

    task automatic check_output();
        check("pending", 32'(o_pending), 32'(m_pending));
        check("fifo_full", 32'(o_fifo_full), 32'(fifo_q.size() == FIFO_DEPTH));
        check("evt_valid", 32'(o_evt_valid), 32'(fifo_q.size() != 0));
        check("merge", 32'(o_merge), 32'(m_merge));
        if (fifo_q.size() != 0) check("head_idx", 32'(o_evt_idx), 32'(fifo_q[0]));
`ifdef BTN_EVT_DROP_CNT_EN
        check("merge_cnt", 32'(o_merge_cnt), 32'(m_cnt));
`endif
    endtask

    task automatic apply_stimulus(input logic [N_BTN-1:0] p, input logic r);
        btn = p;
        rdy = r;
        model_step(p, r);
        @(posedge clk);
        #1;
        check_output();
    endtask

    // Assert reset between edges, confirm outputs clear at once, release after an edge
    task automatic reset_dut(input string tag);
        btn = '0;
        rdy = 1'b0;
        reset = 1'b0;
        #1;
        check({tag, "_valid"}, 32'(o_evt_valid), 32'd0);
        check({tag, "_idx"}, 32'(o_evt_idx), 32'd0);
        check({tag, "_pending"}, 32'(o_pending), 32'd0);
        check({tag, "_full"}, 32'(o_fifo_full), 32'd0);
        check({tag, "_merge"}, 32'(o_merge), 32'd0);
`ifdef BTN_EVT_DROP_CNT_EN
        check({tag, "_merge_cnt"}, 32'(o_merge_cnt), 32'd0);
`endif
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Monitor: every handshake must deliver the oldest expected event
    always @(negedge clk) begin
        int exp_idx;
        if (reset && o_evt_valid && rdy) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL sb_underflow actual=%0d expected=none", o_evt_idx);
            end else begin
                exp_idx = sb_q.pop_front();
                check("sb_evt_idx", 32'(o_evt_idx), 32'(exp_idx));
            end
        end
    end

    initial begin
        int dens;
        int rdy_pct;
        logic [N_BTN-1:0] p;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_dut("rst0");

        // Single press on button 2, consumer stalled, then released
        repeat (8) apply_stimulus('0, 1'b0);
        apply_stimulus(5'b00100, 1'b0);
        check("single_pending", 32'(o_pending), 32'b00100);
        apply_stimulus('0, 1'b0);
        check("single_valid", 32'(o_evt_valid), 32'd1);
        check("single_idx", 32'(o_evt_idx), 32'd2);
        repeat (3) apply_stimulus('0, 1'b0);
        apply_stimulus('0, 1'b1);
        check("single_drained", 32'(o_evt_valid), 32'd0);

        // Simultaneous presses, then round-robin fairness from rr_ptr=4
        reset_dut("rst1");
        apply_stimulus(5'b01011, 1'b1);
        repeat (4) apply_stimulus('0, 1'b1);
        apply_stimulus(5'b10001, 1'b1);
        repeat (4) apply_stimulus('0, 1'b1);

        // Full FIFO backpressure and merge
        reset_dut("rst2");
        for (int k = 0; k < N_BTN; k++) apply_stimulus(N_BTN'(1) << k, 1'b0);
        apply_stimulus('0, 1'b0);
        check("full_flag", 32'(o_fifo_full), 32'd1);
        check("full_pending", 32'(o_pending), 32'b10000);
        apply_stimulus(5'b10000, 1'b0);
        check("full_merge", 32'(o_merge), 32'd1);
        apply_stimulus('0, 1'b0);
        check("merge_one_cycle", 32'(o_merge), 32'd0);
        repeat (8) apply_stimulus('0, 1'b1);

        // Same-cycle grant and press on button 1
        reset_dut("rst3");
        apply_stimulus(5'b00010, 1'b0);
        apply_stimulus(5'b00010, 1'b0);
        check("regrant_pending", 32'(o_pending), 32'b00010);
        repeat (2) apply_stimulus('0, 1'b0);
        repeat (4) apply_stimulus('0, 1'b1);

        // Reset mid-stream with three queued events
        reset_dut("rst4");
        apply_stimulus(5'b00001, 1'b0);
        apply_stimulus(5'b00010, 1'b0);
        apply_stimulus(5'b00100, 1'b0);
        apply_stimulus('0, 1'b0);
        reset_dut("midrst");
        repeat (5) apply_stimulus('0, 1'b1);

        // Randomized traffic with varying press density and ready probability
        dens = 20;
        rdy_pct = 50;
        for (int n = 0; n < 800; n++) begin
            if (n % 100 == 0) begin
                dens    = int'($urandom_range(5, 60));
                rdy_pct = int'($urandom_range(10, 95));
            end
            p = '0;
            for (int k = 0; k < N_BTN; k++) begin
                if (int'($urandom_range(0, 99)) < dens) p[k] = 1'b1;
            end
            apply_stimulus(p, int'($urandom_range(0, 99)) < rdy_pct);
        end

        // Drain everything still pending or queued, bounded
        for (int n = 0; n < 50; n++) begin
            if (sb_q.size() == 0 && fifo_q.size() == 0 && m_pending == '0) break;
            apply_stimulus('0, 1'b1);
        end
        check("drain_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_event_arbiter.md
Name: btn_event_arbiter

Overview:
- Collects one-cycle press pulses from up to N_BTN debounced/one-pulsed buttons and holds each in a per-button pending latch.
- Round-robin arbitrates pending presses into a small event FIFO.
- Presents button indices to the downstream Braille control logic over a valid/ready handshake.
- Sits between the per-button debounce/one-pulse instances and the character/cell FSM, so no press is lost while the consumer is busy.

Parameters:
- N_BTN, 5, number of button pulse inputs (2..16).
- FIFO_DEPTH, 4, event FIFO entries; power of two, 2..16.
- IDX_W, derived localparam = clog2(N_BTN), width of an event index.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- i_btn_pulse  in  N_BTN  one-cycle press pulses, bit k = button k
- o_evt_valid  out  1  FIFO head holds a valid event
- o_evt_idx  out  IDX_W  button index at FIFO head
- i_evt_ready  in  1  consumer accepts the head event this cycle
- o_pending  out  N_BTN  pending latch state, registered
- o_fifo_full  out  1  FIFO count == FIFO_DEPTH
- o_merge  out  1  one-cycle pulse: a press merged into an already-pending latch

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low. While reset is low, all state clears immediately:
  - pending = 0, FIFO count/pointers = 0, rr_ptr = 0
  - o_evt_valid = 0, o_evt_idx = 0, o_fifo_full = 0, o_merge = 0
- Pending latch bit k:
  - Set on i_btn_pulse[k].
  - Cleared on the edge at which k is granted.
  - If a pulse and a grant of k occur in the same cycle, the bit stays set; the new press is preserved.
- Merge: a pulse on k while pending[k]=1 and k is not granted that cycle is absorbed. o_merge = 1 for the following cycle. Only one merge pulse is produced, regardless of how many bits merge.
- Arbiter state machine, states IDLE and GRANT:
  - IDLE: pending == 0, or FIFO full. No push.
  - GRANT: pending != 0 and count < FIFO_DEPTH.
    - Select the first pending index searching upward from rr_ptr, modulo N_BTN.
    - Push that index into the FIFO, clear its pending bit, and set rr_ptr = granted + 1 (wraps to 0 after N_BTN-1).
  - At most one grant per cycle.
  - The full check uses the current count only. A same-cycle pop does not allow a push into a full FIFO.
- FIFO:
  - Show-ahead. o_evt_valid = (count != 0). o_evt_idx = mem[rd_ptr], held stable while valid && !ready.
  - Pop on o_evt_valid && i_evt_ready.
  - Simultaneous push and pop when 0 < count < DEPTH: count unchanged, both pointers advance.
  - Pointers wrap modulo FIFO_DEPTH.
  - Ready while empty has no effect.
- Latency:
  - Pulse sampled at edge t: pending set at t.
  - Grant and push at edge t+1.
  - o_evt_valid high after edge t+1 when the FIFO was empty, i.e. 2 cycles from pulse assertion to valid.
- Backpressure: with the FIFO full, pending bits accumulate, and further presses on pending bits merge. No event is ever reordered for the same button.
- Index width: o_evt_idx is zero-extended to IDX_W. Indices >= N_BTN never occur.
- Reset mid-operation: FIFO contents and pending presses are discarded. o_evt_valid falls asynchronously.

Optional Feature:
- Macro: BTN_EVT_DROP_CNT_EN.
- Defined:
  - Adds output o_merge_cnt [7:0], counting merge events.
  - Saturates at 255.
  - Cleared by reset.
  - Cleared synchronously on a cycle where o_evt_valid && i_evt_ready && o_evt_idx == 0 and the FIFO becomes empty.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Single press: pulse bit 2 at cycle 10, i_evt_ready=0 → o_pending[2]=1 at 11; o_evt_valid=1, o_evt_idx=2 at 12; held until ready, then valid=0 next cycle.
- Simultaneous presses: pulse bits 0,1,3 in one cycle, ready=1, rr_ptr=0 → events 0,1,3 on consecutive cycles; rr_ptr ends at 4.
- Round-robin fairness: after granting 3, pulse 0 and 4 together → 4 granted before 0.
- Full FIFO: ready=0, pulse 0..4 one per cycle, DEPTH=4 → 4 entries, o_fifo_full=1, pending=5'b10000. Pulse 4 again → o_merge pulse. Raise ready → 5 events total, 4 last.
- Same-cycle grant and pulse on bit 1 → event 1 pushed and pending[1] stays 1 → second event 1 follows.
- Assert reset low mid-stream with 3 queued → o_evt_valid=0 immediately; after release, no events emitted; with BTN_EVT_DROP_CNT_EN, o_merge_cnt=0.
